cnn_pass_scheduler: RTL and testbench

- Sequencer for the two-layer conv accelerator top.
- Loads weights for targets 0..4 in order: four L1 cores, then L2. Then runs up to NUM_PASSES compute passes.
- Each pass drives its own L1/L2 weight-base addresses, gates start_compute, and waits for compute_done.
- Sits between the host control register block and the accelerator control inputs. It also monitors the weight AXI-Stream handshake.

---
 rtl/cnn_sched_pkg.sv | 20 ++
 rtl/cnn_pass_desc_ram.sv | 31 +++
 rtl/cnn_pass_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_cnn_pass_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared constants for the conv pass scheduler: FSM encoding, descriptor field layout, load targets.
package cnn_sched_pkg;

  localparam logic [2:0] ST_IDLE          = 3'd0;
  localparam logic [2:0] ST_LOAD_REQ      = 3'd1;
  localparam logic [2:0] ST_LOAD_W        = 3'd2;
  localparam logic [2:0] ST_COMPUTE_SETUP = 3'd3;
  localparam logic [2:0] ST_COMPUTE       = 3'd4;
  localparam logic [2:0] ST_NEXT          = 3'd5;
  localparam logic [2:0] ST_DONE          = 3'd6;

  // Descriptor word is {l2_base, l1_base}; field index times BASE_W gives the LSB.
  localparam int DESC_L1_FIELD = 0;
  localparam int DESC_L2_FIELD = 1;

  // Targets 0..3 are the L1 cores, the last target is L2.
  localparam int L2_TARGET_ID    = 4;
  localparam int DEF_NUM_TARGETS = L2_TARGET_ID + 1;

endpackage

// File: rtl/cnn_pass_desc_ram.sv
// Pass descriptor table: synchronous write, registered read with same-cycle write bypass.
// Contents clear on reset so an unprogrammed pass reads as base 0.
module cnn_pass_desc_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cnn_pass_scheduler.sv
// Weight-load then multi-pass compute sequencer; start->load 1 cycle, tlast->gate 2, done->gate 3.
// Define SCHED_TIMEOUT_EN to add a watchdog on the weight-stream and compute waits.
module cnn_pass_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int NUM_PASSES  = 4,
  parameter int BASE_W      = 9,
  parameter int NUM_TARGETS = DEF_NUM_TARGETS
`ifdef SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_PASSES)-1:0] cfg_addr,
  input  logic [2*BASE_W-1:0]           cfg_wdata,
  input  logic [$clog2(NUM_PASSES):0]   cfg_num_passes,
  input  logic                          i_start,
  input  logic                          i_reload_weights,
  input  logic                          i_w_tvalid,
  input  logic                          i_w_tready,
  input  logic                          i_w_tlast,
  output logic                          o_w_req,
  output logic                          o_load_weights,
  output logic [3:0]                    o_target_layer,
  output logic                          o_start_compute,
  output logic [BASE_W-1:0]             o_l1_weight_base,
  output logic [BASE_W-1:0]             o_l2_weight_base,
  input  logic                          i_compute_done,
  output logic [$clog2(NUM_PASSES)-1:0] o_pass_idx,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error
);

  localparam int PW  = $clog2(NUM_PASSES);
  localparam int NPW = PW + 1;
  localparam logic [PW:0] NP_MAX   = NPW'(NUM_PASSES);
  localparam logic [3:0]  TGT_LAST = 4'(NUM_TARGETS - 1);

  logic [2:0]        state_q, state_d;
  logic [PW:0]       np_q, np_d;
  logic [3:0]        target_q, target_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [BASE_W-1:0] l1_q, l1_d, l2_q, l2_d;
  logic              err_q, err_d;
  logic [2*BASE_W-1:0] desc_rd;
  logic [PW:0]       pass_inc;
  logic              tlast_hs;
  logic              wd_hit;

  assign tlast_hs = i_w_tvalid & i_w_tready & i_w_tlast;
  assign pass_inc = {1'b0, pass_q} + NPW'(1);

  // Read address follows the next pass so the registered read lines up with COMPUTE_SETUP.
  cnn_pass_desc_ram #(.DEPTH(NUM_PASSES), .W(2*BASE_W)) u_desc (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (cfg_we & (state_q == ST_IDLE)),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (pass_d),
    .rdata_o (desc_rd)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wd_cnt_q;
  logic          wait_st;

  assign wait_st = (state_q == ST_LOAD_W) || (state_q == ST_COMPUTE);
  assign wd_hit  = wait_st && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd_cnt_q <= '0;
    else if (state_d != state_q) wd_cnt_q <= '0;
    else if (wait_st)            wd_cnt_q <= wd_cnt_q + CW'(1);
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    np_d     = np_q;
    target_d = target_q;
    pass_d   = pass_q;
    l1_d     = l1_q;
    l2_d     = l2_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          np_d     = cfg_num_passes;
          target_d = '0;
          pass_d   = '0;
          err_d    = 1'b0;
          if (cfg_num_passes == '0) begin
            state_d = ST_DONE;
          end else if (cfg_num_passes > NP_MAX) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = i_reload_weights ? ST_LOAD_REQ : ST_COMPUTE_SETUP;
          end
        end
      end
      ST_LOAD_REQ: state_d = ST_LOAD_W;
      ST_LOAD_W: begin
        if (tlast_hs) begin
          if (target_q == TGT_LAST) begin
            state_d = ST_COMPUTE_SETUP;
          end else begin
            target_d = target_q + 4'd1;
            state_d  = ST_LOAD_REQ;
          end
        end else if (wd_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_COMPUTE_SETUP: begin
        l1_d    = desc_rd[DESC_L1_FIELD*BASE_W +: BASE_W];
        l2_d    = desc_rd[DESC_L2_FIELD*BASE_W +: BASE_W];
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (i_compute_done) begin
          state_d = ST_NEXT;
        end else if (wd_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_NEXT: begin
        if (pass_inc == np_q) begin
          state_d = ST_DONE;
        end else begin
          pass_d  = pass_inc[PW-1:0];
          state_d = ST_COMPUTE_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      np_q     <= '0;
      target_q <= '0;
      pass_q   <= '0;
      l1_q     <= '0;
      l2_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      np_q     <= np_d;
      target_q <= target_d;
      pass_q   <= pass_d;
      l1_q     <= l1_d;
      l2_q     <= l2_d;
      err_q    <= err_d;
    end
  end

  assign o_w_req          = (state_q == ST_LOAD_W);
  assign o_load_weights   = (state_q == ST_LOAD_REQ);
  assign o_start_compute  = (state_q == ST_COMPUTE);
  assign o_busy           = (state_q != ST_IDLE);
  assign o_done           = (state_q == ST_DONE);
  assign o_target_layer   = target_q;
  assign o_l1_weight_base = l1_q;
  assign o_l2_weight_base = l2_q;
  assign o_pass_idx       = pass_q;
  assign o_error          = err_q;

endmodule

// File: tb/tb_cnn_pass_scheduler.sv
// Bench for cnn_pass_scheduler: directed and randomized jobs against a job-level reference model.
module tb_cnn_pass_scheduler;

  localparam int NUM_PASSES  = 4;
  localparam int BASE_W      = 9;
  localparam int NUM_TARGETS = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [17:0] cfg_wdata = '0;
  logic [2:0]  cfg_num_passes = '0;
  logic        i_start = 1'b0, i_reload_weights = 1'b0;
  logic        i_w_tvalid = 1'b0, i_w_tready = 1'b0, i_w_tlast = 1'b0;
  logic        i_compute_done = 1'b0;
  logic        o_w_req, o_load_weights, o_start_compute, o_busy, o_done, o_error;
  logic [3:0]  o_target_layer;
  logic [8:0]  o_l1_weight_base, o_l2_weight_base;
  logic [1:0]  o_pass_idx;

  cnn_pass_scheduler #(
    .NUM_PASSES(NUM_PASSES), .BASE_W(BASE_W), .NUM_TARGETS(NUM_TARGETS)
`ifdef SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num_passes(cfg_num_passes), .i_start(i_start), .i_reload_weights(i_reload_weights),
    .i_w_tvalid(i_w_tvalid), .i_w_tready(i_w_tready), .i_w_tlast(i_w_tlast),
    .o_w_req(o_w_req), .o_load_weights(o_load_weights), .o_target_layer(o_target_layer),
    .o_start_compute(o_start_compute), .o_l1_weight_base(o_l1_weight_base),
    .o_l2_weight_base(o_l2_weight_base), .i_compute_done(i_compute_done),
    .o_pass_idx(o_pass_idx), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference view of the descriptor table as the host believes it to be.
  logic [8:0] m_l1 [NUM_PASSES];
  logic [8:0] m_l2 [NUM_PASSES];

  int          ld_q[$];
  logic [31:0] gate_q[$];
  int          done_cnt = 0, unstable = 0;
  logic        err_at_done = 1'b0, gate_prev = 1'b0;
  logic [17:0] base_prev = '0;

  always @(negedge clk) begin
    if (o_load_weights) ld_q.push_back(int'(o_target_layer));
    if (o_start_compute && !gate_prev)
      gate_q.push_back({12'd0, o_pass_idx, o_l2_weight_base, o_l1_weight_base});
    if (o_start_compute && gate_prev && ({o_l2_weight_base, o_l1_weight_base} != base_prev))
      unstable++;
    gate_prev = o_start_compute;
    base_prev = {o_l2_weight_base, o_l1_weight_base};
    if (o_done) begin
      done_cnt++;
      err_at_done = o_error;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ld_q.delete();
    gate_q.delete();
    done_cnt = 0;
    unstable = 0;
    err_at_done = 1'b0;
  endtask

  task automatic idle_inputs();
    i_w_tvalid = 1'b0; i_w_tready = 1'b0; i_w_tlast = 1'b0;
    i_compute_done = 1'b0; cfg_we = 1'b0; i_start = 1'b0;
  endtask

  task automatic write_desc(input int idx, input logic [8:0] l1, input logic [8:0] l2);
    cfg_we = 1'b1; cfg_addr = 2'(idx); cfg_wdata = {l2, l1};
    tick();
    cfg_we = 1'b0;
    m_l1[idx] = l1;
    m_l2[idx] = l2;
  endtask

  task automatic run_job(input string tag, input int np, input bit reload, input int beats,
                         input int lat, input bit noise);
    int cyc, beats_left, hi, exp_rise, n_ld, n_g;
    bit prev_sc, valid;
    logic [31:0] exp_g;
    valid = (np >= 1) && (np <= NUM_PASSES);
    clear_mon();
    cyc = 0; hi = 0; beats_left = 0; prev_sc = 0;
    exp_rise = reload ? -1 : 2;
    cfg_num_passes = 3'(np); i_reload_weights = reload; i_start = 1'b1;
    tick();
    cyc = 1; i_start = 1'b0;
    check($sformatf("%s_ld_lat", tag), o_load_weights, valid && reload);
    while (!o_done && cyc < 5000) begin
      idle_inputs();
      if (o_load_weights) begin
        beats_left = beats;
        i_w_tvalid = 1'b1; i_w_tready = 1'b1; i_w_tlast = 1'b1;
      end else if (o_w_req) begin
        i_w_tvalid = ($urandom_range(0, 3) != 0);
        i_w_tready = ($urandom_range(0, 3) != 0);
        i_w_tlast  = (beats_left == 1);
        if (i_w_tvalid && i_w_tready) begin
          beats_left--;
          if (beats_left == 0 && o_target_layer == 4'(NUM_TARGETS - 1)) exp_rise = cyc + 2;
        end
      end else if (o_start_compute) begin
        if (!prev_sc) begin
          check($sformatf("%s_gate_lat", tag), cyc, exp_rise);
          hi = 0;
        end
        hi++;
        if (hi == lat) begin
          i_compute_done = 1'b1;
          exp_rise = cyc + 3;
        end
      end
      if (noise && o_busy && $urandom_range(0, 5) == 0) begin
        i_start = 1'b1; cfg_we = 1'b1;
        cfg_addr = 2'($urandom_range(0, 3)); cfg_wdata = 18'($urandom);
      end
      prev_sc = o_start_compute;
      tick();
      cyc++;
    end
    idle_inputs();
    check($sformatf("%s_done_seen", tag), o_done, 1);
    tick();
    check($sformatf("%s_idle", tag), o_busy, 0);
    check($sformatf("%s_done_pulse", tag), o_done, 0);
    check($sformatf("%s_done_cnt", tag), done_cnt, 1);
    check($sformatf("%s_err_at_done", tag), err_at_done, np > NUM_PASSES);
    check($sformatf("%s_err_sticky", tag), o_error, np > NUM_PASSES);
    n_ld = (valid && reload) ? NUM_TARGETS : 0;
    check($sformatf("%s_ld_cnt", tag), ld_q.size(), n_ld);
    for (int i = 0; i < n_ld && i < ld_q.size(); i++)
      check($sformatf("%s_ld_tgt%0d", tag, i), ld_q[i], i);
    n_g = valid ? np : 0;
    check($sformatf("%s_gate_cnt", tag), gate_q.size(), n_g);
    for (int p = 0; p < n_g && p < gate_q.size(); p++) begin
      exp_g = {12'd0, 2'(p), m_l2[p], m_l1[p]};
      check($sformatf("%s_gate%0d", tag, p), gate_q[p], exp_g);
    end
    check($sformatf("%s_stable", tag), unstable, 0);
  endtask

  initial begin
    int cnt, hi;
    for (int i = 0; i < NUM_PASSES; i++) begin m_l1[i] = '0; m_l2[i] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_outs", {o_w_req, o_load_weights, o_start_compute, o_done, o_error}, 0);
    check("rst_bases", {o_l1_weight_base, o_l2_weight_base, o_target_layer, o_pass_idx}, 0);
    rst_n = 1'b1;
    tick();

    // compute_done while idle is ignored
    i_compute_done = 1'b1;
    repeat (3) tick();
    i_compute_done = 1'b0;
    check("idle_done_busy", o_busy, 0);
    check("idle_done_gate", o_start_compute, 0);

    // Full job from the plan
    write_desc(0, 9'h000, 9'h040);
    write_desc(1, 9'h020, 9'h060);
    run_job("full", 2, 1'b1, 9, 50, 1'b0);

    run_job("noreload", 1, 1'b0, 1, 5, 1'b0);
    run_job("np0", 0, 1'b1, 1, 1, 1'b0);
    run_job("np5", 5, 1'b0, 1, 1, 1'b0);
    run_job("clr_err", 2, 1'b0, 1, 3, 1'b0);

    // Randomized jobs with ignored starts and table writes while busy
    for (int j = 0; j < 6; j++) begin
      for (int d = 0; d < NUM_PASSES; d++)
        write_desc(d, 9'($urandom), 9'($urandom));
      run_job($sformatf("rnd%0d", j), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
              $urandom_range(1, 9), $urandom_range(1, 20), 1'b1);
    end

    // Reset in the middle of pass 1
    write_desc(0, 9'h1a5, 9'h0c3);
    write_desc(1, 9'h111, 9'h0ee);
    cfg_num_passes = 3'd2; i_reload_weights = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cnt = 0;
    while (!o_start_compute && cnt < 100) begin tick(); cnt++; end
    repeat (3) tick();
    i_compute_done = 1'b1;
    tick();
    i_compute_done = 1'b0;
    cnt = 0;
    while (!(o_start_compute && o_pass_idx == 2'd1) && cnt < 100) begin tick(); cnt++; end
    check("mid_pass1", {o_start_compute, o_pass_idx}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {o_busy, o_start_compute, o_w_req, o_load_weights, o_done, o_error}, 0);
    check("mid_rst_data", {o_l1_weight_base, o_l2_weight_base, o_target_layer, o_pass_idx}, 0);
    for (int i = 0; i < NUM_PASSES; i++) begin m_l1[i] = '0; m_l2[i] = '0; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run_job("post_rst", 2, 1'b0, 1, 4, 1'b0);

`ifdef SCHED_TIMEOUT_EN
    // Withheld compute_done trips the watchdog after 100 gate cycles
    write_desc(0, 9'h033, 9'h044);
    cfg_num_passes = 3'd1; i_reload_weights = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cnt = 0; hi = 0;
    while (!o_done && cnt < 1000) begin
      if (o_start_compute) hi++;
      tick();
      cnt++;
    end
    check("to_gate_cycles", hi, 100);
    check("to_done", o_done, 1);
    check("to_error", o_error, 1);
    check("to_gate_off", o_start_compute, 0);
    tick();
    check("to_idle", o_busy, 0);
    check("to_err_sticky", o_error, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
